// File: rtl/servo_uart_frame_rx.sv
// UART receiver and 4-byte position frame parser feeding the X/Y servo PWM stages.
// Frame: 0xFF, X, Y, X^Y. Positions update only on a fully valid frame.
// Optional watchdog (SERVO_RX_WATCHDOG_EN) recentres the plate when frames stop.
module servo_uart_frame_rx #(
    parameter int unsigned CLK_HZ         = 50000000,
    parameter int unsigned BAUD           = 9600,
    parameter logic [6:0]  CENTRE         = 7'd64,
    parameter int unsigned TIMEOUT_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [6:0] pos_x,
    output logic [6:0] pos_y,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned DIV    = CLK_HZ / (BAUD * 16);
    localparam int unsigned TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(DIV - 1);

    typedef enum logic [1:0] {ByteIdle, ByteStart, ByteData, ByteStop} byte_state_e;
    typedef enum logic [1:0] {ParWaitSync, ParGetX, ParGetY, ParGetChk} par_state_e;

    logic              rx_meta_q, rx_sync_q;
    byte_state_e       byte_state_q, byte_state_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]        os_q, os_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              tick, sample, byte_ok, byte_ferr;

    par_state_e        par_q, par_d;
    logic [6:0]        shx_q, shx_d, shy_q, shy_d;
    logic [6:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic              frame_valid_q, frame_valid_d, frame_err_q, frame_err_d;
    logic              par_err;

`ifdef SERVO_RX_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_FIRE = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_q, wd_d;
`else
    // Timeout only matters when the watchdog is built.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Two-flop synchroniser; idles high so reset cannot fake a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign tick   = (tick_cnt_q == TICK_MAX);
    // Oversample counter runs free across bits, so mid-bit recurs every 16 ticks.
    assign sample = tick && (os_q == 4'd7);

    // Byte FSM next state: start/data/stop sampling at oversample 8.
    always_comb begin
        byte_state_d = byte_state_q;
        tick_cnt_d   = tick ? '0 : tick_cnt_q + TICK_W'(1);
        os_d         = tick ? os_q + 4'd1 : os_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_ok      = 1'b0;
        byte_ferr    = 1'b0;
        unique case (byte_state_q)
            ByteIdle: begin
                tick_cnt_d = '0;
                os_d       = '0;
                if (!rx_sync_q) byte_state_d = ByteStart;
            end
            ByteStart: begin
                if (sample) begin
                    if (rx_sync_q) begin
                        byte_state_d = ByteIdle;
                    end else begin
                        byte_state_d = ByteData;
                        bit_cnt_d    = '0;
                    end
                end
            end
            ByteData: begin
                if (sample) begin
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) byte_state_d = ByteStop;
                end
            end
            ByteStop: begin
                if (sample) begin
                    byte_state_d = ByteIdle;
                    byte_ok      = rx_sync_q;
                    byte_ferr    = !rx_sync_q;
                end
            end
            default: byte_state_d = ByteIdle;
        endcase
    end

    // Parser next state and output loads (plus watchdog recentring when built).
    always_comb begin
        par_d         = par_q;
        shx_d         = shx_q;
        shy_d         = shy_q;
        pos_x_d       = pos_x_q;
        pos_y_d       = pos_y_q;
        frame_valid_d = 1'b0;
        par_err       = 1'b0;
        if (byte_ferr) begin
            par_d = ParWaitSync;
        end else if (byte_ok) begin
            unique case (par_q)
                ParWaitSync: if (shift_q == 8'hFF) par_d = ParGetX;
                ParGetX, ParGetY: begin
                    if (!shift_q[7]) begin
                        if (par_q == ParGetX) begin
                            shx_d = shift_q[6:0];
                            par_d = ParGetY;
                        end else begin
                            shy_d = shift_q[6:0];
                            par_d = ParGetChk;
                        end
                    end else if (shift_q == 8'hFF) begin
                        par_d = ParGetX;
                    end else begin
                        par_err = 1'b1;
                        par_d   = ParWaitSync;
                    end
                end
                ParGetChk: begin
                    if (shift_q == {1'b0, shx_q ^ shy_q}) begin
                        pos_x_d       = shx_q;
                        pos_y_d       = shy_q;
                        frame_valid_d = 1'b1;
                    end else begin
                        par_err = 1'b1;
                    end
                    par_d = ParWaitSync;
                end
                default: par_d = ParWaitSync;
            endcase
        end
        frame_err_d = byte_ferr | par_err;
`ifdef SERVO_RX_WATCHDOG_EN
        wd_d = wd_q;
        if (frame_valid_d) begin
            wd_d = '0;
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + WD_W'(1);
            // Load fires only on the step into saturation, never again while held.
            if (wd_q == WD_FIRE) begin
                pos_x_d = CENTRE;
                pos_y_d = CENTRE;
            end
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_state_q  <= ByteIdle;
            tick_cnt_q    <= '0;
            os_q          <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            par_q         <= ParWaitSync;
            shx_q         <= '0;
            shy_q         <= '0;
            pos_x_q       <= CENTRE;
            pos_y_q       <= CENTRE;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            byte_state_q  <= byte_state_d;
            tick_cnt_q    <= tick_cnt_d;
            os_q          <= os_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            shx_q         <= shx_d;
            shy_q         <= shy_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

`ifdef SERVO_RX_WATCHDOG_EN
    // Watchdog counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wd_q <= '0;
        else       wd_q <= wd_d;
    end
`endif

    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign rx_busy     = (byte_state_q != ByteIdle);

endmodule

// File: tb/tb_servo_uart_frame_rx.sv
// Self-checking bench for servo_uart_frame_rx: directed + randomized frames against a
// queue-based frame model. Define SERVO_RX_WATCHDOG_EN to exercise the watchdog.
module tb_servo_uart_frame_rx;

    localparam int unsigned BIT_CLK = 160;
    localparam logic [6:0]  CTR     = 7'd64;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [6:0] pos_x, pos_y;
    logic       frame_valid, frame_err, rx_busy;

    servo_uart_frame_rx #(
        .CLK_HZ        (1600000),
        .BAUD          (10000),
        .CENTRE        (CTR),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Observed pulse counts and position-change bookkeeping.
    int         fv_cnt = 0, fe_cnt = 0, both_cnt = 0, stray_cnt = 0;
    logic [6:0] last_fv_x = '0, last_fv_y = '0, prev_x = '0, prev_y = '0;

    always @(negedge clk) begin
        if (reset) begin
            prev_x <= pos_x;
            prev_y <= pos_y;
        end else begin
            if (frame_valid) begin
                fv_cnt    <= fv_cnt + 1;
                last_fv_x <= pos_x;
                last_fv_y <= pos_y;
            end
            if (frame_err) fe_cnt <= fe_cnt + 1;
            if (frame_valid && frame_err) both_cnt <= both_cnt + 1;
            if (((pos_x != prev_x) || (pos_y != prev_y)) && !frame_valid)
                stray_cnt <= stray_cnt + 1;
            prev_x <= pos_x;
            prev_y <= pos_y;
        end
    end

    // Reference model: bytes collected since the last sync, applied by the frame rules.
    logic [7:0] frm[$];
    int         exp_fv = 0, exp_fe = 0;
    logic [6:0] exp_x = CTR, exp_y = CTR;

    task automatic model_byte(input logic [7:0] b);
        if (frm.size() == 0) begin
            if (b == 8'hFF) frm.push_back(b);
        end else if (frm.size() < 3) begin
            if (b == 8'hFF) begin
                frm.delete();
                frm.push_back(b);
            end else if (b < 8'd128) begin
                frm.push_back(b);
            end else begin
                exp_fe++;
                frm.delete();
            end
        end else begin
            if (b == (frm[1] ^ frm[2])) begin
                exp_x = frm[1][6:0];
                exp_y = frm[2][6:0];
                exp_fv++;
            end else begin
                exp_fe++;
            end
            frm.delete();
        end
    endtask

    // Position expected once more than the watchdog timeout has passed since a valid frame.
    function automatic logic [6:0] held(input logic [6:0] v);
`ifdef SERVO_RX_WATCHDOG_EN
        return CTR;
`else
        return v;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rx = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        model_byte(b);
    endtask

    // Stop bit held low just past its sample point, then the line idles.
    task automatic send_bad_stop(input logic [7:0] b);
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        exp_fe++;
        frm.delete();
    endtask

    task automatic send_frame(input logic [7:0] x, input logic [7:0] y, input logic [7:0] c);
        send_byte(8'hFF);
        send_byte(x);
        send_byte(y);
        send_byte(c);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_fv"}, fv_cnt, exp_fv);
        check({tag, "_fe"}, fe_cnt, exp_fe);
    endtask

    initial begin
        logic [7:0] rx_x, rx_y, rx_c;
        reset = 1'b1;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // Reset state.
        check("rst_pos_x", pos_x, CTR);
        check("rst_pos_y", pos_y, CTR);
        check("rst_fv", frame_valid, 1'b0);
        check("rst_fe", frame_err, 1'b0);
        check("rst_busy", rx_busy, 1'b0);

        // Valid frame.
        send_frame(8'h20, 8'h50, 8'h70);
        check_counts("t2");
        check("t2_pos_x", pos_x, exp_x);
        check("t2_pos_y", pos_y, exp_y);
        check("t2_pulse_x", last_fv_x, 7'h20);
        check("t2_pulse_y", last_fv_y, 7'h50);

        // Checksum error leaves positions alone.
        send_frame(8'h20, 8'h50, 8'h71);
        check_counts("t3");
        check("t3_pos_x", pos_x, held(exp_x));
        check("t3_pos_y", pos_y, held(exp_y));

        // Resync on a second 0xFF, then a bad-MSB byte, then a stray byte in WAIT_SYNC.
        send_byte(8'hFF);
        send_byte(8'h10);
        send_frame(8'h05, 8'h06, 8'h03);
        check_counts("t4a");
        check("t4_pos_x", pos_x, 7'h05);
        check("t4_pos_y", pos_y, 7'h06);
        send_byte(8'hFF);
        send_byte(8'h85);
        check_counts("t4b");
        send_byte(8'h10);
        send_frame(8'h7F, 8'h01, 8'h7E);
        check_counts("t4c");
        check("t4c_pos_x", pos_x, exp_x);

        // Framing error mid-frame drops back to WAIT_SYNC.
        send_byte(8'hFF);
        send_byte(8'h11);
        send_bad_stop(8'h55);
        check_counts("t5_stop");
        send_byte(8'h22);
        send_frame(8'h33, 8'h44, 8'h77);
        check_counts("t5_after");
        check("t5_pos_y", pos_y, exp_y);

        // Short low glitch on the idle line.
        rx = 1'b0;
        repeat (20) @(negedge clk);
        check("t5_glitch_busy", rx_busy, 1'b1);
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        check("t5_glitch_idle", rx_busy, 1'b0);
        repeat (300) @(negedge clk);
        check_counts("t5_glitch");
        check("t5_glitch_pos", pos_x, held(exp_x));

        // Reset in the middle of the Y byte.
        send_byte(8'hFF);
        send_byte(8'h20);
        rx = 1'b0;
        repeat (3 * BIT_CLK) @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_rst_pos_x", pos_x, CTR);
        check("t5_rst_busy", rx_busy, 1'b0);
        reset = 1'b0;
        frm.delete();
        exp_x = CTR;
        exp_y = CTR;
        repeat (300) @(negedge clk);
        check("t5_rst_pos_y", pos_y, CTR);
        send_frame(8'h01, 8'h02, 8'h03);
        check_counts("t5_rst");
        check("t5_rst_new_x", pos_x, 7'h01);
        check("t5_rst_new_y", pos_y, 7'h02);

        // Randomized frames, some with a corrupted checksum.
        for (int n = 0; n < 2; n++) begin
            rx_x = 8'($urandom_range(0, 127));
            rx_y = 8'($urandom_range(0, 127));
            rx_c = rx_x ^ rx_y;
            if ($urandom_range(0, 1) == 1) rx_c = rx_c ^ 8'(1 << $urandom_range(0, 6));
            send_frame(rx_x, rx_y, rx_c);
            check_counts("rnd");
            if (rx_c == (rx_x ^ rx_y)) begin
                check("rnd_pos_x", pos_x, exp_x);
                check("rnd_pos_y", pos_y, exp_y);
            end else begin
                check("rnd_hold_x", pos_x, held(exp_x));
            end
        end

        // Idle behaviour after a valid frame.
        send_frame(8'h30, 8'h30, 8'h00);
        check("t6_pos_x", pos_x, 7'h30);
        repeat (700) @(negedge clk);
        check("t6_before", pos_x, 7'h30);
        repeat (400) @(negedge clk);
`ifdef SERVO_RX_WATCHDOG_EN
        check("t6_wd_x", pos_x, CTR);
        check("t6_wd_y", pos_y, CTR);
`else
        check("t6_hold_x", pos_x, 7'h30);
        check("t6_hold_y", pos_y, 7'h30);
        check("stray_updates", stray_cnt, 0);
`endif
        check_counts("t6");
        check("fv_fe_overlap", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
